// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin: one full_subtractor cell reused over WIDTH cycles,
// LSB first, with the borrow carried between cycles in a register.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic difference,
   output logic borrow
);
   assign difference = a ^ b ^ c;
   assign borrow     = (~a & b) | (~(a ^ b) & c);
endmodule

// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one bit processed per edge, LSB first
// DONE  | result valid, done pulse; may accept a new start back-to-back
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] op_a, op_b, res, res_nx;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             cell_diff, cell_borrow;
   logic             accept, last;

   full_subtractor u_fs (
      .a          (op_a[cnt[IW-1:0]]),
      .b          (op_b[cnt[IW-1:0]]),
      .c          (borrow_q),
      .difference (cell_diff),
      .borrow     (cell_borrow)
   );

   // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
   assign res_nx = WIDTH'({cell_diff, res} >> 1);
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         res        <= '0;
         borrow_q   <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_a     <= a;
            op_b     <= b;
            borrow_q <= bin;
            cnt      <= '0;
            res      <= '0;
         end else if (state == RUN) begin
            res      <= res_nx;
            borrow_q <= cell_borrow;
            cnt      <= cnt + CW'(1);
            if (last) begin
               diff       <= res_nx;
               borrow_out <= cell_borrow;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
endmodule
